cpu_clock_ctrl: RTL and testbench

//  Upstream run/step/halt controller for the CPU sequencer, derived from mclk.

---
 rtl/cpu_clock_ctrl.sv | 95 +++++++++
 tb/tb_cpu_clock_ctrl.sv | 95 +++++++++
 2 files changed

// File: rtl/cpu_clock_ctrl.sv
// cpu_clock_ctrl: debounced run/step/halt controller issuing cpu_tick and disp_tick strobes from mclk.
module cpu_clock_ctrl #(
   parameter int CPU_DIV    = 16666666,
   parameter int DISP_DIV   = 263158,
   parameter int DB_CNT     = 500000,
   parameter int STEP_TICKS = 4
) (
   input  logic mclk,
   input  logic clr_n,
   input  logic btn_run,
   input  logic btn_step,
   input  logic halt,
   output logic cpu_tick,
   output logic disp_tick,
   output logic running,
   output logic halted
);
   localparam int PW = CPU_DIV > 1 ? $clog2(CPU_DIV) : 1;
   localparam int DW = DISP_DIV > 1 ? $clog2(DISP_DIV) : 1;
   localparam int BW = DB_CNT > 1 ? $clog2(DB_CNT) : 1;
   localparam int SW = $clog2(2 * STEP_TICKS);
   typedef enum logic [1:0] {STOPPED, RUN, STEP, HALTED} state_t;
   state_t state_q, state_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [SW-1:0] step_q, step_d;
   logic [DW-1:0] disp_q, disp_d;
   logic [1:0] s1_q, s2_q, db_q, db_d, dbp_q;
   logic [BW-1:0] dbc_q [2];
   logic [BW-1:0] dbc_d [2];
   logic tick_q, tick_d, disp_tick_q, running_q, halted_q;
   logic run_press, step_press;
   // bit 0 is the run button, bit 1 the step button
   always_comb begin
      db_d = db_q;
      for (int i = 0; i < 2; i++) begin
         dbc_d[i] = '0;
         if (s2_q[i] != db_q[i]) begin
            if (dbc_q[i] == BW'(DB_CNT - 1)) db_d[i] = s2_q[i];
            else dbc_d[i] = dbc_q[i] + 1'b1;
         end
      end
   end
   assign run_press  = db_q[0] & ~dbp_q[0];
   assign step_press = db_q[1] & ~dbp_q[1];
   always_comb begin
      state_d = state_q;
      case (state_q)
         STOPPED: state_d = halt ? HALTED : run_press ? RUN : step_press ? STEP : STOPPED;
         RUN:     state_d = halt ? HALTED : run_press ? STOPPED : RUN;
         STEP:    state_d = halt ? HALTED : (step_q == SW'(2 * STEP_TICKS - 1)) ? STOPPED : STEP;
         default: state_d = HALTED;
      endcase
      presc_d = (state_q == RUN && state_d == RUN) ?
                (presc_q == PW'(CPU_DIV - 1) ? '0 : presc_q + 1'b1) : '0;
      // step_q counts STEP cycles; even counts are tick cycles, odd are gaps
      step_d = (state_q == STEP && state_d == STEP) ? step_q + 1'b1 : '0;
      tick_d = (state_d == RUN && presc_d == PW'(CPU_DIV - 1)) || (state_d == STEP && !step_d[0]);
      disp_d = (disp_q == DW'(DISP_DIV - 1)) ? '0 : disp_q + 1'b1;
   end
   always_ff @(posedge mclk or negedge clr_n)
      if (!clr_n) begin
         state_q     <= STOPPED;
         presc_q     <= '0;
         step_q      <= '0;
         disp_q      <= '0;
         s1_q        <= '0;
         s2_q        <= '0;
         db_q        <= '0;
         dbp_q       <= '0;
         dbc_q       <= '{default: '0};
         tick_q      <= 1'b0;
         disp_tick_q <= 1'b0;
         running_q   <= 1'b0;
         halted_q    <= 1'b0;
      end else begin
         state_q     <= state_d;
         presc_q     <= presc_d;
         step_q      <= step_d;
         disp_q      <= disp_d;
         s1_q        <= {btn_step, btn_run};
         s2_q        <= s1_q;
         db_q        <= db_d;
         dbp_q       <= db_q;
         dbc_q       <= dbc_d;
         tick_q      <= tick_d;
         disp_tick_q <= (disp_d == DW'(DISP_DIV - 1));
         running_q   <= (state_d == RUN);
         halted_q    <= (state_d == HALTED);
      end
   // a tick landing in the cycle halt rises is dropped
   assign cpu_tick  = tick_q & ~halt;
   assign disp_tick = disp_tick_q;
   assign running   = running_q;
   assign halted    = halted_q;
endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// tb_cpu_clock_ctrl: directed scoreboard bench for cpu_clock_ctrl with small divider parameters.
module tb_cpu_clock_ctrl;
   logic mclk = 1'b0;
   logic clr_n = 1'b0;
   logic btn_run = 1'b0;
   logic btn_step = 1'b0;
   logic halt = 1'b0;
   logic cpu_tick, disp_tick, running, halted;
   logic [3:0] sb [$];
   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   string phase = "reset";

   cpu_clock_ctrl #(.CPU_DIV(4), .DISP_DIV(3), .DB_CNT(2), .STEP_TICKS(4)) dut (
      .mclk(mclk), .clr_n(clr_n), .btn_run(btn_run), .btn_step(btn_step), .halt(halt),
      .cpu_tick(cpu_tick), .disp_tick(disp_tick), .running(running), .halted(halted)
   );

   always #5 mclk = ~mclk;

   task automatic compare();
      logic [3:0] exp_v, obs_v;
      exp_v = sb.pop_front();
      obs_v = {cpu_tick, disp_tick, running, halted};
      vectors++;
      assert (obs_v === exp_v) else begin
         miscompares++;
         $error("FAIL %s cyc=%0d {tick,disp,run,halt} got=%b exp=%b", phase, cyc, obs_v, exp_v);
      end
   endtask

   task automatic step(input logic r, input logic s, input logic h,
                       input logic et, input logic er, input logic eh);
      btn_run = r;
      btn_step = s;
      halt = h;
      sb.push_back({et, (cyc % 3 == 2), er, eh});
      @(negedge mclk);
      compare();
      cyc++;
      @(posedge mclk);
      #1;
   endtask

   task automatic do_reset(input string tag);
      phase = tag;
      clr_n = 1'b0;
      btn_run = 1'b0;
      btn_step = 1'b0;
      halt = 1'b0;
      repeat (2) begin
         sb.push_back(4'b0000);
         @(negedge mclk);
         compare();
         @(posedge mclk);
         #1;
      end
      clr_n = 1'b1;
      cyc = 0;
   endtask

   initial begin
      @(posedge mclk);
      #1;
      do_reset("reset");
      phase = "idle";
      while (cyc < 12) step(0, 0, 0, 0, 0, 0);
      phase = "run_stop";
      while (cyc < 36)
         step((cyc >= 12 && cyc < 18) || (cyc >= 24 && cyc < 30), 0, 0,
              cyc == 20 || cyc == 24 || cyc == 28, cyc >= 17 && cyc < 29, 0);
      phase = "step";
      while (cyc < 56)
         step(0, cyc >= 36 && cyc < 48, 0, cyc inside {41, 43, 45, 47}, 0, 0);
      phase = "glitch";
      while (cyc < 64) step(cyc == 56, 0, 0, 0, 0, 0);
      phase = "run_again";
      while (cyc < 74) step(cyc < 70, 0, 0, cyc == 72, cyc >= 69, 0);
      do_reset("mid_run_reset");
      phase = "after_reset";
      while (cyc < 4) step(0, 0, 0, 0, 0, 0);
      phase = "step_halt";
      while (cyc < 18)
         step(0, cyc >= 4 && cyc < 10, cyc == 12 || cyc == 13,
              cyc == 9 || cyc == 11, 0, cyc >= 13);
      do_reset("halted_reset");
      phase = "run_halt";
      while (cyc < 40)
         step((cyc >= 4 && cyc < 10) || (cyc >= 20 && cyc < 26), cyc >= 30 && cyc < 36,
              cyc == 16, cyc == 12, cyc >= 9 && cyc < 17, cyc >= 17);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
